// File: rtl/terminal_tx_fifo.sv
// Transmit queue for one router terminal port: host pushes packets, router pops
// the head via the pndng/pop handshake.
module terminal_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out_i_in,
  output logic                     pndng_i_in,
  input  logic                     pop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             pop_ok, push_ok, full_w;

  // Next-state: pointers, occupancy and sticky error flags.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    full_w  = (count_q == CW'(DEPTH));
    pop_ok  = pop && (count_q != '0);
    push_ok = push && (!full_w || pop_ok);

    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new error event in the same cycle as clr_err keeps the flag set.
    if (push && !push_ok)    ovf_d = 1'b1;
    else if (clr_err)        ovf_d = 1'b0;
    if (pop && !pop_ok)      unf_d = 1'b1;
    else if (clr_err)        unf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not cleared by reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign pndng_i_in    = (count_q != '0);
  assign full          = (count_q == CW'(DEPTH));
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;
  assign data_out_i_in = pndng_i_in ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_terminal_tx_fifo.sv
// Directed bench for terminal_tx_fifo: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_terminal_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 40;

  logic              clk = 1'b0;
  logic              rst, push, pop, clr_err;
  logic [WIDTH-1:0]  push_data;
  logic              full, overflow, underflow, pndng_i_in;
  logic [4:0]        count;
  logic [WIDTH-1:0]  data_out_i_in;

  terminal_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data),
    .full(full), .count(count), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err), .data_out_i_in(data_out_i_in),
    .pndng_i_in(pndng_i_in), .pop(pop)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned passed = 0;

  logic [WIDTH-1:0] mq [$];
  logic             m_ovf, m_unf;
  logic [WIDTH-1:0] got;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare.
  task automatic cycle();
    logic popv, pusha;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      popv  = pop && (mq.size() != 0);
      pusha = push && ((mq.size() < DEPTH) || popv);
      if (popv)  void'(mq.pop_front());
      if (pusha) mq.push_back(push_data);
      if (push && !pusha) m_ovf = 1'b1;
      else if (clr_err)   m_ovf = 1'b0;
      if (pop && !popv)   m_unf = 1'b1;
      else if (clr_err)   m_unf = 1'b0;
    end
    @(negedge clk);
    chk("m_pndng", 64'(pndng_i_in), 64'(mq.size() != 0));
    chk("m_data",  64'(data_out_i_in), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_full",  64'(full), 64'(mq.size() == DEPTH));
    chk("m_ovf",   64'(overflow), 64'(m_ovf));
    chk("m_unf",   64'(underflow), 64'(m_unf));
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = '0;
  endtask

  initial begin
    m_ovf = 1'b0; m_unf = 1'b0;
    idle();
    rst = 1'b1;
    cycle(); cycle();
    chk("rst_pndng", 64'(pndng_i_in), 64'd0);
    chk("rst_data",  64'(data_out_i_in), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flags", 64'({full, overflow, underflow}), 64'd0);
    rst = 1'b0;

    // Single push then pop.
    push = 1'b1; push_data = 40'hA5_0000_0001;
    cycle(); idle();
    chk("t1_pndng", 64'(pndng_i_in), 64'd1);
    chk("t1_data",  64'(data_out_i_in), 64'h00A5_0000_0001);
    chk("t1_count", 64'(count), 64'd1);
    pop = 1'b1;
    cycle(); idle();
    chk("t1_pop_pndng", 64'(pndng_i_in), 64'd0);
    chk("t1_pop_data",  64'(data_out_i_in), 64'd0);
    chk("t1_pop_count", 64'(count), 64'd0);

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; push_data = 40'(i);
      cycle();
    end
    idle();
    chk("fill_full",  64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd16);
    push = 1'b1; push_data = 40'hFF;
    cycle(); idle();
    chk("ovf_flag",  64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_head",  64'(data_out_i_in), 64'd0);
    clr_err = 1'b1;
    cycle(); idle();
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Push with pop while full.
    push = 1'b1; pop = 1'b1; push_data = 40'h77;
    cycle(); idle();
    chk("fpp_count", 64'(count), 64'd16);
    chk("fpp_ovf",   64'(overflow), 64'd0);
    chk("fpp_head",  64'(data_out_i_in), 64'd1);

    // Drain: 1..15 then 0x77, never 0xFF.
    for (int i = 0; i < 16; i++) begin
      got = data_out_i_in;
      chk("drain", 64'(got), (i < 15) ? 64'(i + 1) : 64'h77);
      pop = 1'b1;
      cycle();
    end
    idle();
    chk("drain_empty", 64'(pndng_i_in), 64'd0);

    // Underflow and clear priority.
    pop = 1'b1;
    cycle(); idle();
    chk("unf_set",   64'(underflow), 64'd1);
    chk("unf_count", 64'(count), 64'd0);
    clr_err = 1'b1;
    cycle(); idle();
    chk("unf_clr", 64'(underflow), 64'd0);
    clr_err = 1'b1; pop = 1'b1;
    cycle(); idle();
    chk("unf_set_wins", 64'(underflow), 64'd1);
    clr_err = 1'b1;
    cycle(); idle();

    // Push and pop together on an empty FIFO.
    push = 1'b1; pop = 1'b1; push_data = 40'h55;
    cycle(); idle();
    chk("epp_unf",   64'(underflow), 64'd1);
    chk("epp_count", 64'(count), 64'd1);
    chk("epp_data",  64'(data_out_i_in), 64'h55);
    pop = 1'b1; clr_err = 1'b1;
    cycle(); idle();

    // Sustained push+pop at occupancy 3, wrapping the pointers.
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_data = 40'(100 + i);
      cycle();
    end
    for (int i = 0; i < 40; i++) begin
      got = data_out_i_in;
      chk("stream_head", 64'(got), (i < 3) ? 64'(100 + i) : 64'(200 + i - 3));
      push = 1'b1; pop = 1'b1; push_data = 40'(200 + i);
      cycle();
      chk("stream_count", 64'(count), 64'd3);
    end
    idle();
    chk("stream_tail", 64'(data_out_i_in), 64'd237);

    // Mid-stream reset with push and pop asserted.
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_data = 40'(300 + i);
      cycle();
    end
    rst = 1'b1; push = 1'b1; pop = 1'b1; push_data = 40'h99;
    cycle(); idle(); rst = 1'b0;
    chk("mrst_pndng", 64'(pndng_i_in), 64'd0);
    chk("mrst_data",  64'(data_out_i_in), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_flags", 64'({full, overflow, underflow}), 64'd0);
    push = 1'b1; push_data = 40'h1;
    cycle(); idle();
    chk("post_rst_data",  64'(data_out_i_in), 64'd1);
    chk("post_rst_count", 64'(count), 64'd1);
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
